// File: rtl/lbm_step_sequencer.sv
// LBM time-step sequencer: collide -> stream -> boundary -> advance, for MAX_TIME steps.
// Optional snapshot handshake every SNAPSHOT_INTERVAL steps when LBM_SEQ_SNAPSHOT_EN is defined.

module lbm_step_sequencer #(
  parameter int MAX_TIME          = 100,
  parameter int TIME_COUNT_WIDTH  = $clog2(MAX_TIME),
  parameter int SNAPSHOT_INTERVAL = 10
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Run,
  input  logic                      Pause,
  input  logic                      Clear,
  output logic                      Collide_start,
  input  logic                      Collide_done,
  output logic                      Stream_start,
  input  logic                      Stream_done,
  output logic                      Bound_start,
  input  logic                      Bound_done,
  output logic                      Step_en,
  output logic                      Snap_req,
  input  logic                      Snap_ack,
  output logic [TIME_COUNT_WIDTH:0] Time_step,
  output logic [2:0]                Phase,
  output logic                      Busy,
  output logic                      Finished
);

  localparam int TW = TIME_COUNT_WIDTH + 1;
  localparam logic [TW-1:0] LAST = TW'(MAX_TIME);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLIDE = 3'd1,
    S_STREAM  = 3'd2,
    S_BOUND   = 3'd3,
    S_ADVANCE = 3'd4,
    S_PAUSED  = 3'd5,
    S_SNAP    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [TW-1:0]   ts_inc;
  logic            clr_cnt;
  logic            adv;
  logic            snap_hit;

  // End-of-step routing once the count (and any snapshot) is settled
  function automatic state_t decide(input logic last, input logic pause);
    if (last)       return S_DONE;
    else if (pause) return S_PAUSED;
    else            return S_COLLIDE;
  endfunction

  assign ts_inc = Time_step + TW'(1);

  always_comb begin
    state_nx = state;
    clr_cnt  = 1'b0;
    adv      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Run) state_nx = S_COLLIDE;
      end
      // A done landing in the start cycle belongs to nothing yet
      S_COLLIDE: begin
        if (!Collide_start && Collide_done) state_nx = S_STREAM;
      end
      S_STREAM: begin
        if (!Stream_start && Stream_done) state_nx = S_BOUND;
      end
      S_BOUND: begin
        if (!Bound_start && Bound_done) state_nx = S_ADVANCE;
      end
      S_ADVANCE: begin
        adv = 1'b1;
        if (snap_hit) state_nx = S_SNAP;
        else          state_nx = decide(ts_inc == LAST, Pause);
      end
      S_SNAP: begin
`ifdef LBM_SEQ_SNAPSHOT_EN
        if (Snap_ack) state_nx = decide(Time_step == LAST, Pause);
`else
        state_nx = S_IDLE;
`endif
      end
      S_PAUSED: begin
        if (Clear) begin
          state_nx = S_IDLE;
          clr_cnt  = 1'b1;
        end else if (Run) begin
          state_nx = S_COLLIDE;
        end
      end
      S_DONE: begin
        if (Clear) begin
          state_nx = S_IDLE;
          clr_cnt  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state         <= S_IDLE;
      Time_step     <= '0;
      Collide_start <= 1'b0;
      Stream_start  <= 1'b0;
      Bound_start   <= 1'b0;
      Step_en       <= 1'b0;
    end else begin
      state         <= state_nx;
      Collide_start <= (state_nx == S_COLLIDE) && (state != S_COLLIDE);
      Stream_start  <= (state_nx == S_STREAM) && (state != S_STREAM);
      Bound_start   <= (state_nx == S_BOUND) && (state != S_BOUND);
      Step_en       <= (state_nx == S_ADVANCE);
      if (clr_cnt)
        Time_step <= '0;
      else if (adv && Time_step != LAST)
        Time_step <= ts_inc;
    end
  end

`ifdef LBM_SEQ_SNAPSHOT_EN
  localparam int SW = $clog2(SNAPSHOT_INTERVAL + 1);
  localparam logic [SW-1:0] SNAP_LAST = SW'(SNAPSHOT_INTERVAL - 1);

  logic [SW-1:0] snap_cnt;

  assign snap_hit = adv && (snap_cnt == SNAP_LAST);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      snap_cnt <= '0;
      Snap_req <= 1'b0;
    end else begin
      Snap_req <= (state_nx == S_SNAP);
      if (clr_cnt || snap_hit)
        snap_cnt <= '0;
      else if (adv)
        snap_cnt <= snap_cnt + SW'(1);
    end
  end
`else
  localparam int snap_interval_unused = SNAPSHOT_INTERVAL;
  logic snap_ack_unused;

  assign snap_ack_unused = Snap_ack;
  assign snap_hit        = 1'b0;
  assign Snap_req        = 1'b0;
`endif

  assign Phase    = state;
  assign Busy     = !(state inside {S_IDLE, S_PAUSED, S_DONE});
  assign Finished = (state == S_DONE);

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Bench for lbm_step_sequencer: three instances (MAX_TIME 3, 8, 4), bench-side engines,
// a spec-level cycle model compared every cycle, plus directed literal checks.

module tb_lbm_step_sequencer;

  localparam int N = 3;
  localparam int MAXS [N] = '{3, 8, 4};
  localparam int INTV = 2;
`ifdef LBM_SEQ_SNAPSHOT_EN
  localparam bit SNAP_ON = 1'b1;
`else
  localparam bit SNAP_ON = 1'b0;
`endif

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst_n [N];
  logic       run   [N];
  logic       pause [N];
  logic       clear [N];
  logic [3:1] done_a [N];
  logic [3:1] done_m [N];
  logic       ack   [N];
  logic       cs    [N];
  logic       ss    [N];
  logic       bs    [N];
  logic       se    [N];
  logic       sr    [N];
  logic       busy  [N];
  logic       fin   [N];
  logic [2:0] ph    [N];
  logic [7:0] ts    [N];

  bit auto_en [N];
  int cyc = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = $clog2(MAXS[g]) + 1;
    logic [W-1:0] ts_w;
    lbm_step_sequencer #(
      .MAX_TIME(MAXS[g]),
      .SNAPSHOT_INTERVAL(INTV)
    ) u_dut (
      .Clk(Clk),
      .Reset(rst_n[g]),
      .Run(run[g]),
      .Pause(pause[g]),
      .Clear(clear[g]),
      .Collide_start(cs[g]),
      .Collide_done(done_a[g][1] | done_m[g][1]),
      .Stream_start(ss[g]),
      .Stream_done(done_a[g][2] | done_m[g][2]),
      .Bound_start(bs[g]),
      .Bound_done(done_a[g][3] | done_m[g][3]),
      .Step_en(se[g]),
      .Snap_req(sr[g]),
      .Snap_ack(ack[g]),
      .Time_step(ts_w),
      .Phase(ph[g]),
      .Busy(busy[g]),
      .Finished(fin[g])
    );
    assign ts[g] = 8'(ts_w);
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Engines answer 2 cycles after start; snapshot ack 3 cycles after req
  int dly [N][4];
  int sc  [N];
  int last_ack [N];
  initial begin
    for (int i = 0; i < N; i++) begin
      done_a[i] = '0;
      ack[i] = 1'b0;
      sc[i] = 0;
      last_ack[i] = -1;
      for (int p = 0; p < 4; p++) dly[i][p] = 0;
    end
    forever begin
      @(negedge Clk);
      for (int i = 0; i < N; i++) begin
        for (int p = 1; p <= 3; p++) begin
          done_a[i][p] = 1'b0;
          if (!auto_en[i]) begin
            dly[i][p] = 0;
          end else begin
            if (dly[i][p] > 0) begin
              dly[i][p]--;
              if (dly[i][p] == 0) done_a[i][p] = 1'b1;
            end
            if ((p == 1 && cs[i]) || (p == 2 && ss[i]) || (p == 3 && bs[i]))
              dly[i][p] = 2;
          end
        end
        ack[i] = 1'b0;
        if (sr[i]) begin
          sc[i]++;
          if (sc[i] == 4) begin
            ack[i] = 1'b1;
            sc[i] = 0;
            last_ack[i] = cyc;
          end
        end else begin
          sc[i] = 0;
        end
      end
    end
  end

  // Event recorder
  string order_a = "";
  int    steps [N];
  int    ts_q [N][$];
  int    snap_ts [N][$];
  int    fin_cyc [N];
  logic  prev_sr [N];
  logic  prev_fin [N];
  logic [7:0] prev_ts [N];
  initial begin
    for (int i = 0; i < N; i++) begin
      steps[i] = 0;
      fin_cyc[i] = -1;
      prev_sr[i] = 1'b0;
      prev_fin[i] = 1'b0;
      prev_ts[i] = '0;
    end
    forever begin
      @(negedge Clk);
      if (cs[0]) order_a = {order_a, "C"};
      if (ss[0]) order_a = {order_a, "S"};
      if (bs[0]) order_a = {order_a, "B"};
      for (int i = 0; i < N; i++) begin
        if (se[i]) steps[i]++;
        if (ts[i] != prev_ts[i] && ts[i] != 0) ts_q[i].push_back(int'(ts[i]));
        if (sr[i] && !prev_sr[i]) snap_ts[i].push_back(int'(ts[i]));
        if (fin[i] && !prev_fin[i]) fin_cyc[i] = cyc;
        prev_ts[i] = ts[i];
        prev_sr[i] = sr[i];
        prev_fin[i] = fin[i];
      end
    end
  end

  // Spec-level model: phase number, first-cycle flag, completed-step count
  int m_ph [N];
  int m_ts [N];
  bit m_fresh [N];

  task automatic go(input int i, input int p);
    m_ph[i] = p;
    m_fresh[i] = 1'b1;
  endtask

  task automatic end_of_step(input int i);
    if (m_ts[i] == MAXS[i]) go(i, 7);
    else if (pause[i]) go(i, 5);
    else go(i, 1);
  endtask

  task automatic model_edge(input int i);
    logic [3:1] d;
    d = done_a[i] | done_m[i];
    if (!rst_n[i]) begin
      m_ph[i] = 0;
      m_ts[i] = 0;
      m_fresh[i] = 1'b0;
      return;
    end
    case (m_ph[i])
      0: if (run[i]) go(i, 1);
      1, 2, 3: begin
        if (!m_fresh[i] && d[m_ph[i]]) go(i, m_ph[i] + 1);
        else m_fresh[i] = 1'b0;
      end
      4: begin
        m_ts[i]++;
        if (SNAP_ON && (m_ts[i] % INTV) == 0) go(i, 6);
        else end_of_step(i);
      end
      6: if (ack[i]) end_of_step(i);
      5: begin
        if (clear[i]) begin
          m_ph[i] = 0;
          m_ts[i] = 0;
        end else if (run[i]) go(i, 1);
      end
      7: begin
        if (clear[i]) begin
          m_ph[i] = 0;
          m_ts[i] = 0;
        end
      end
      default: m_ph[i] = 0;
    endcase
  endtask

  initial begin
    logic [17:0] exp_v;
    logic [17:0] got_v;
    for (int i = 0; i < N; i++) begin
      m_ph[i] = 0;
      m_ts[i] = 0;
      m_fresh[i] = 1'b0;
    end
    forever begin
      @(posedge Clk);
      cyc++;
      for (int i = 0; i < N; i++) model_edge(i);
      #1;
      for (int i = 0; i < N; i++) begin
        exp_v = {3'(m_ph[i]), 8'(m_ts[i]),
                 m_fresh[i] && m_ph[i] == 1,
                 m_fresh[i] && m_ph[i] == 2,
                 m_fresh[i] && m_ph[i] == 3,
                 m_ph[i] == 4, m_ph[i] == 6,
                 m_ph[i] inside {1, 2, 3, 4, 6},
                 m_ph[i] == 7};
        got_v = {ph[i], ts[i], cs[i], ss[i], bs[i], se[i], sr[i],
                 busy[i], fin[i]};
        chk($sformatf("cycle%0d inst%0d outputs", cyc, i), int'(got_v), int'(exp_v));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_ph(input int i, input int p, input int budget, input string nm);
    int n = 0;
    while (int'(ph[i]) != p && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk(nm, int'(ph[i]), p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0;
      run[i] = 1'b0;
      pause[i] = 1'b0;
      clear[i] = 1'b0;
      done_m[i] = '0;
      auto_en[i] = 1'b0;
    end
    tick(3);
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    tick(1);
    chk("reset phase A", int'(ph[0]), 0);
    chk("reset time_step A", int'(ts[0]), 0);

    // Full run on MAX_TIME=3
    auto_en[0] = 1'b1;
    run[0] = 1'b1;
    tick(1);
    run[0] = 1'b0;
    chk("run to collide_start", int'(cs[0]), 1);
    wait_ph(0, 7, 300, "A reaches DONE");
    chk("A start order", int'(order_a == "CSBCSBCSB"), 1);
    chk("A step_en pulses", steps[0], 3);
    chk("A time_step count", ts_q[0].size(), 3);
    for (int k = 0; k < ts_q[0].size() && k < 3; k++)
      chk($sformatf("A time_step value %0d", k), ts_q[0][k], k + 1);
    chk("A finished", int'(fin[0]), 1);
    run[0] = 1'b1;
    tick(3);
    run[0] = 1'b0;
    chk("A run in DONE phase", int'(ph[0]), 7);
    chk("A run in DONE time_step", int'(ts[0]), 3);
    clear[0] = 1'b1;
    tick(1);
    clear[0] = 1'b0;
    chk("A clear phase", int'(ph[0]), 0);
    chk("A clear time_step", int'(ts[0]), 0);
    auto_en[0] = 1'b0;

    // Handshake rules on MAX_TIME=8
    run[1] = 1'b1;
    tick(1);
    run[1] = 1'b0;
    chk("B collide_start", int'(cs[1]), 1);
    done_m[1][1] = 1'b1;
    tick(1);
    done_m[1][1] = 1'b0;
    chk("early collide_done ignored", int'(ph[1]), 1);
    chk("no stream_start on early done", int'(ss[1]), 0);
    done_m[1][1] = 1'b1;
    tick(1);
    done_m[1][1] = 1'b0;
    chk("stream_start after collide_done", int'(ss[1]), 1);
    tick(1);
    done_m[1][3] = 1'b1;
    tick(1);
    done_m[1][3] = 1'b0;
    chk("bound_done in STREAM ignored", int'(ph[1]), 2);
    done_m[1][2] = 1'b1;
    tick(1);
    done_m[1][2] = 1'b0;
    chk("bound_start after stream_done", int'(bs[1]), 1);
    tick(1);
    done_m[1][3] = 1'b1;
    tick(1);
    done_m[1][3] = 1'b0;
    chk("step_en after bound_done", int'(se[1]), 1);
    auto_en[1] = 1'b1;
    tick(1);
    chk("B time_step after advance", int'(ts[1]), 1);
    chk("B next collide_start", int'(cs[1]), 1);

    // Reset in BOUND of step 6
    n = 0;
    while (!(ts[1] == 8'd5 && ph[1] == 3'd3) && n < 400) begin
      tick(1);
      n++;
    end
    chk("B reaches BOUND at 5", int'(ts[1] == 8'd5 && ph[1] == 3'd3), 1);
    auto_en[1] = 1'b0;
    rst_n[1] = 1'b0;
    tick(1);
    chk("mid-BOUND reset time_step", int'(ts[1]), 0);
    chk("mid-BOUND reset phase", int'(ph[1]), 0);
    chk("mid-BOUND reset strobes",
        int'({cs[1], ss[1], bs[1], se[1], sr[1], busy[1], fin[1]}), 0);
    tick(1);
    rst_n[1] = 1'b1;
    tick(1);
    done_m[1][3] = 1'b1;
    tick(1);
    done_m[1][3] = 1'b0;
    tick(1);
    chk("late bound_done ignored phase", int'(ph[1]), 0);
    chk("late bound_done ignored step", int'(ts[1]), 0);

    // Pause / resume / run+clear
    auto_en[1] = 1'b1;
    run[1] = 1'b1;
    tick(1);
    run[1] = 1'b0;
    n = 0;
    while (!(ts[1] == 8'd1 && ph[1] == 3'd2) && n < 400) begin
      tick(1);
      n++;
    end
    pause[1] = 1'b1;
    wait_ph(1, 5, 200, "pause reaches PAUSED");
    chk("paused time_step", int'(ts[1]), 2);
    pause[1] = 1'b0;
    run[1] = 1'b1;
    tick(1);
    run[1] = 1'b0;
    chk("resume collide_start", int'(cs[1]), 1);
    pause[1] = 1'b1;
    wait_ph(1, 5, 200, "second pause");
    chk("second paused time_step", int'(ts[1]), 3);
    pause[1] = 1'b0;
    run[1] = 1'b1;
    clear[1] = 1'b1;
    tick(1);
    run[1] = 1'b0;
    clear[1] = 1'b0;
    chk("run+clear phase", int'(ph[1]), 0);
    chk("run+clear time_step", int'(ts[1]), 0);
    auto_en[1] = 1'b0;

    // Full run on MAX_TIME=4 (snapshot points at 2 and 4 when enabled)
    auto_en[2] = 1'b1;
    run[2] = 1'b1;
    tick(1);
    run[2] = 1'b0;
    wait_ph(2, 7, 400, "C reaches DONE");
    chk("C time_step", int'(ts[2]), 4);
    chk("C step_en pulses", steps[2], 4);
    chk("C snap_req count", snap_ts[2].size(), SNAP_ON ? 2 : 0);
`ifdef LBM_SEQ_SNAPSHOT_EN
    if (snap_ts[2].size() == 2) begin
      chk("C first snap step", snap_ts[2][0], 2);
      chk("C second snap step", snap_ts[2][1], 4);
    end
    chk("C finished after last ack", fin_cyc[2] - last_ack[2], 1);
`endif
    tick(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
